// File: rtl/rtc_timekeeper_if.sv
// Control, load and display signals of the real-time clock, grouped for rtc_timekeeper.
// master drives the requests; slave (the timekeeper) drives the time display and pulses.
interface rtc_timekeeper_if;
   logic       ena;
   logic       mode24;
   logic       load;
   logic [7:0] ld_hh, ld_mm, ld_ss;
   logic       ld_pm;
   logic       alarm_set;
   logic [7:0] al_hh, al_mm;
   logic       al_pm;
   logic       alarm_arm;
   logic [7:0] hh, mm, ss;
   logic       pm;
   logic       sec_pulse;
   logic       day_wrap;
   logic       load_err;
   logic       alarm_hit;

   modport master (
      output ena, mode24, load, ld_hh, ld_mm, ld_ss, ld_pm,
             alarm_set, al_hh, al_mm, al_pm, alarm_arm,
      input  hh, mm, ss, pm, sec_pulse, day_wrap, load_err, alarm_hit
   );
   modport slave (
      input  ena, mode24, load, ld_hh, ld_mm, ld_ss, ld_pm,
             alarm_set, al_hh, al_mm, al_pm, alarm_arm,
      output hh, mm, ss, pm, sec_pulse, day_wrap, load_err, alarm_hit
   );
endinterface

// File: rtl/rtc_timekeeper.sv
// Binary hh:mm:ss timekeeper with prescaler, BCD load and 12/24-hour display.
// Alarm storage and matching exist only when RTC_TIMEKEEPER_ALARM_EN is defined.
module rtc_timekeeper #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic           clk,
   input  logic           reset,
   rtc_timekeeper_if.slave bus
);
   localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

   function automatic logic nib_ok(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   function automatic logic [5:0] bcd2bin(input logic [7:0] b);
      return 6'(b[7:4]) * 6'd10 + 6'(b[3:0]);
   endfunction

   function automatic logic hour_ok(input logic [7:0] b, input logic m24);
      return nib_ok(b) && (m24 ? (b <= 8'h23) : (b >= 8'h01 && b <= 8'h12));
   endfunction

   function automatic logic min_ok(input logic [7:0] b);
      return nib_ok(b) && (b <= 8'h59);
   endfunction

   // 12-hour entry: 12 am is hour 0, 12 pm is hour 12, other pm hours add 12
   function automatic logic [4:0] hour_in(input logic [7:0] b, input logic pm, input logic m24);
      logic [4:0] h;
      h = 5'(bcd2bin(b));
      if (m24) return h;
      if (h == 5'd12) return pm ? 5'd12 : 5'd0;
      return pm ? h + 5'd12 : h;
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [5:0] v);
      logic [3:0] t;
      logic [5:0] r;
      t = 4'd0;
      r = v;
      for (int i = 0; i < 5; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return {t, 4'(r)};
   endfunction

   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  hr_q, hr_d, hr_i, h12;
   logic [5:0]  min_q, min_d, min_i;
   logic [5:0]  sec_q, sec_d, sec_i;
   logic        sec_pulse_q, sec_pulse_d;
   logic        day_wrap_q, day_wrap_d;
   logic        load_err_q, load_err_d;
   logic        tick, ld_ok, ld_acc, adv, al_err;

   always_comb begin
      tick   = bus.ena && (cnt_q == LAST);
      ld_ok  = hour_ok(bus.ld_hh, bus.mode24) && min_ok(bus.ld_mm) && min_ok(bus.ld_ss);
      ld_acc = bus.load && ld_ok;
      adv    = tick && !ld_acc;

      sec_i = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      min_i = min_q;
      hr_i  = hr_q;
      if (sec_q == 6'd59) begin
         min_i = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
         if (min_q == 6'd59) hr_i = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      end

      cnt_d = cnt_q;
      hr_d  = hr_q;
      min_d = min_q;
      sec_d = sec_q;
      if (bus.ena) cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
      // a valid load wins over a same-cycle tick and restarts the second
      if (ld_acc) begin
         hr_d  = hour_in(bus.ld_hh, bus.ld_pm, bus.mode24);
         min_d = bcd2bin(bus.ld_mm);
         sec_d = bcd2bin(bus.ld_ss);
         cnt_d = 32'd0;
      end else if (adv) begin
         hr_d  = hr_i;
         min_d = min_i;
         sec_d = sec_i;
      end

      sec_pulse_d = adv;
      day_wrap_d  = adv && (hr_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);
      load_err_d  = (bus.load && !ld_ok) || al_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         hr_q        <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         hr_q        <= hr_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
         load_err_q  <= load_err_d;
      end
   end

`ifdef RTC_TIMEKEEPER_ALARM_EN
   logic [4:0] al_hr_q, al_hr_d;
   logic [5:0] al_min_q, al_min_d;
   logic       alarm_hit_q, alarm_hit_d;
   logic       al_ok;

   always_comb begin
      al_ok    = hour_ok(bus.al_hh, bus.mode24) && min_ok(bus.al_mm);
      al_err   = bus.alarm_set && !al_ok;
      al_hr_d  = al_hr_q;
      al_min_d = al_min_q;
      if (bus.alarm_set && al_ok) begin
         al_hr_d  = hour_in(bus.al_hh, bus.al_pm, bus.mode24);
         al_min_d = bcd2bin(bus.al_mm);
      end
      // only a tick can fire the alarm; landing on the time via load does not
      alarm_hit_d = adv && bus.alarm_arm && (hr_i == al_hr_q) &&
                    (min_i == al_min_q) && (sec_i == 6'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         al_hr_q     <= '0;
         al_min_q    <= '0;
         alarm_hit_q <= 1'b0;
      end else begin
         al_hr_q     <= al_hr_d;
         al_min_q    <= al_min_d;
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign bus.alarm_hit = alarm_hit_q;
`else
   assign al_err        = 1'b0;
   assign bus.alarm_hit = 1'b0;
`endif

   always_comb begin
      h12 = hr_q;
      if (hr_q == 5'd0)       h12 = 5'd12;
      else if (hr_q > 5'd12)  h12 = hr_q - 5'd12;
   end

   assign bus.hh        = bin2bcd({1'b0, bus.mode24 ? hr_q : h12});
   assign bus.mm        = bin2bcd(min_q);
   assign bus.ss        = bin2bcd(sec_q);
   assign bus.pm        = !bus.mode24 && (hr_q >= 5'd12);
   assign bus.sec_pulse = sec_pulse_q;
   assign bus.day_wrap  = day_wrap_q;
   assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with TICK_DIV=4; alarm checks follow RTC_TIMEKEEPER_ALARM_EN.
module tb_rtc_timekeeper;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   rtc_timekeeper_if bus();

   rtc_timekeeper #(.TICK_DIV(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic p);
      chk({tag, ".hh"}, bus.hh, h);
      chk({tag, ".mm"}, bus.mm, m);
      chk({tag, ".ss"}, bus.ss, s);
      chk({tag, ".pm"}, {7'd0, bus.pm}, {7'd0, p});
   endtask

   task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic p);
      bus.ld_hh = h;
      bus.ld_mm = m;
      bus.ld_ss = s;
      bus.ld_pm = p;
      bus.load  = 1'b1;
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p);
      set_load(h, m, s, p);
      step(1);
      bus.load = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.ena = 1'b1;     bus.mode24 = 1'b0;  bus.load = 1'b0;
      bus.ld_hh = 8'h00;  bus.ld_mm = 8'h00;  bus.ld_ss = 8'h00; bus.ld_pm = 1'b0;
      bus.alarm_set = 1'b0; bus.al_hh = 8'h00; bus.al_mm = 8'h00; bus.al_pm = 1'b0;
      bus.alarm_arm = 1'b0;

      // reset state
      step(2);
      chk_time("rst12", 8'h12, 8'h00, 8'h00, 1'b0);
      chk("rst_sp", {7'd0, bus.sec_pulse}, 8'd0);
      chk("rst_dw", {7'd0, bus.day_wrap}, 8'd0);
      chk("rst_le", {7'd0, bus.load_err}, 8'd0);
      chk("rst_ah", {7'd0, bus.alarm_hit}, 8'd0);
      bus.mode24 = 1'b1; #1;
      chk("rst24_hh", bus.hh, 8'h00);
      bus.mode24 = 1'b0;

      // first second: four enabled cycles after release
      reset = 1'b0;
      step(3);
      chk("pre_sp", {7'd0, bus.sec_pulse}, 8'd0);
      chk("pre_ss", bus.ss, 8'h00);
      step(1);
      chk("first_sp", {7'd0, bus.sec_pulse}, 8'd1);
      chk_time("first", 8'h12, 8'h00, 8'h01, 1'b0);
      step(1);
      chk("first_sp_end", {7'd0, bus.sec_pulse}, 8'd0);

      // 11:59:59 am -> 12:00:00 pm
      do_load(8'h11, 8'h59, 8'h59, 1'b0);
      chk_time("ld_am", 8'h11, 8'h59, 8'h59, 1'b0);
      chk("ld_am_sp", {7'd0, bus.sec_pulse}, 8'd0);
      step(3);
      chk("noon_pre_sp", {7'd0, bus.sec_pulse}, 8'd0);
      step(1);
      chk_time("noon", 8'h12, 8'h00, 8'h00, 1'b1);
      chk("noon_sp", {7'd0, bus.sec_pulse}, 8'd1);
      chk("noon_dw", {7'd0, bus.day_wrap}, 8'd0);

      // 11:59:59 pm -> 12:00:00 am with day_wrap
      do_load(8'h11, 8'h59, 8'h59, 1'b1);
      chk_time("ld_pm", 8'h11, 8'h59, 8'h59, 1'b1);
      step(4);
      chk_time("midnight", 8'h12, 8'h00, 8'h00, 1'b0);
      chk("midnight_dw", {7'd0, bus.day_wrap}, 8'd1);
      step(1);
      chk("midnight_dw_end", {7'd0, bus.day_wrap}, 8'd0);

      // hh=13 rejected in 12-hour mode, time held with ena=0
      bus.ena = 1'b0;
      do_load(8'h13, 8'h00, 8'h00, 1'b0);
      chk("bad_hh_le", {7'd0, bus.load_err}, 8'd1);
      chk_time("bad_hh", 8'h12, 8'h00, 8'h00, 1'b0);
      step(1);
      chk("bad_hh_le_end", {7'd0, bus.load_err}, 8'd0);
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("frz_ss", bus.ss, 8'h00);
         chk("frz_sp", {7'd0, bus.sec_pulse}, 8'd0);
      end
      do_load(8'h12, 8'h60, 8'h00, 1'b0);
      chk("bad_mm_le", {7'd0, bus.load_err}, 8'd1);
      do_load(8'h12, 8'h00, 8'h0A, 1'b0);
      chk("bad_ss_le", {7'd0, bus.load_err}, 8'd1);
      chk_time("bad_ss", 8'h12, 8'h00, 8'h00, 1'b0);

      // hh=13 accepted in 24-hour mode; format change is display-only
      bus.mode24 = 1'b1;
      do_load(8'h13, 8'h00, 8'h00, 1'b0);
      chk("h13_le", {7'd0, bus.load_err}, 8'd0);
      chk_time("h13", 8'h13, 8'h00, 8'h00, 1'b0);
      bus.mode24 = 1'b0; #1;
      chk_time("h13_12h", 8'h01, 8'h00, 8'h00, 1'b1);
      bus.mode24 = 1'b1;

      // load coincident with a tick: load wins, no sec_pulse
      bus.ena = 1'b1;
      step(3);
      set_load(8'h05, 8'h06, 8'h07, 1'b0);
      step(1);
      bus.load = 1'b0;
      chk_time("coll", 8'h05, 8'h06, 8'h07, 1'b0);
      chk("coll_sp", {7'd0, bus.sec_pulse}, 8'd0);
      step(3);
      chk("coll_pre_ss", bus.ss, 8'h07);
      step(1);
      chk("coll_next_ss", bus.ss, 8'h08);
      chk("coll_next_sp", {7'd0, bus.sec_pulse}, 8'd1);

      bus.mode24 = 1'b0;
`ifdef RTC_TIMEKEEPER_ALARM_EN
      // alarm 07:30 am, set in the same cycle as the load
      bus.al_hh = 8'h07; bus.al_mm = 8'h30; bus.al_pm = 1'b0;
      bus.alarm_set = 1'b1; bus.alarm_arm = 1'b1;
      set_load(8'h07, 8'h29, 8'h59, 1'b0);
      step(1);
      bus.load = 1'b0; bus.alarm_set = 1'b0;
      chk("al_le", {7'd0, bus.load_err}, 8'd0);
      chk_time("al_ld", 8'h07, 8'h29, 8'h59, 1'b0);
      step(3);
      chk("al_pre", {7'd0, bus.alarm_hit}, 8'd0);
      step(1);
      chk_time("al_time", 8'h07, 8'h30, 8'h00, 1'b0);
      chk("al_hit", {7'd0, bus.alarm_hit}, 8'd1);
      step(1);
      chk("al_hit_end", {7'd0, bus.alarm_hit}, 8'd0);
      bus.alarm_arm = 1'b0;
      do_load(8'h07, 8'h29, 8'h59, 1'b0);
      step(4);
      chk("disarm_mm", bus.mm, 8'h30);
      chk("disarm_hit", {7'd0, bus.alarm_hit}, 8'd0);
      bus.alarm_arm = 1'b1;
      do_load(8'h07, 8'h30, 8'h00, 1'b0);
      chk("ld_on_al", {7'd0, bus.alarm_hit}, 8'd0);
      step(1);
      chk("ld_on_al2", {7'd0, bus.alarm_hit}, 8'd0);
      bus.al_hh = 8'h13; bus.alarm_set = 1'b1;
      step(1);
      bus.alarm_set = 1'b0;
      chk("bad_al_le", {7'd0, bus.load_err}, 8'd1);
      bus.alarm_arm = 1'b0;
`else
      // alarm inputs are ignored: no load_err, no hit
      bus.al_hh = 8'h13; bus.al_mm = 8'h30; bus.alarm_set = 1'b1; bus.alarm_arm = 1'b1;
      set_load(8'h07, 8'h29, 8'h59, 1'b0);
      step(1);
      bus.load = 1'b0; bus.alarm_set = 1'b0;
      chk("noal_le", {7'd0, bus.load_err}, 8'd0);
      step(4);
      chk_time("noal_time", 8'h07, 8'h30, 8'h00, 1'b0);
      chk("noal_hit", {7'd0, bus.alarm_hit}, 8'd0);
      bus.alarm_arm = 1'b0;
`endif

      // reset mid-count at 05:17:42
      bus.mode24 = 1'b1;
      do_load(8'h05, 8'h17, 8'h42, 1'b0);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk_time("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0);
      bus.mode24 = 1'b0; #1;
      chk_time("mid_rst12", 8'h12, 8'h00, 8'h00, 1'b0);
      step(3);
      chk("mid_rst_pre_sp", {7'd0, bus.sec_pulse}, 8'd0);
      step(1);
      chk("mid_rst_sp", {7'd0, bus.sec_pulse}, 8'd1);
      chk("mid_rst_ss", bus.ss, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rtc_timekeeper.md
RTC_TIMEKEEPER -- requirements
Module: rtc_timekeeper

Interface
REQ-001 Parameter: TICK_DIV, 50000000, enabled clk cycles per second; legal range 1..2^32-1.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ena  input  1  prescaler count enable; when low, all timekeeping freezes.
REQ-005 Port: mode24  input  1  display format; 1 = 24-hour, 0 = 12-hour with pm flag.
REQ-006 Port: load  input  1  one-cycle request to set the time from ld_hh/ld_mm/ld_ss/ld_pm.
REQ-007 Port: ld_hh, ld_mm, ld_ss  input  8 each  BCD load values, interpreted in the current mode format.
REQ-008 Port: ld_pm  input  1  pm flag for the load; used only when mode24=0.
REQ-009 Port: alarm_set  input  1  one-cycle request to set the alarm from al_hh/al_mm/al_pm.
REQ-010 Port: al_hh, al_mm  input  8 each  BCD alarm values, interpreted in the current mode format.
REQ-011 Port: al_pm  input  1  alarm pm flag; used only when mode24=0.
REQ-012 Port: alarm_arm  input  1  level enable for alarm matching.
REQ-013 Port: hh, mm, ss  output  8 each  BCD time display.
REQ-014 Port: pm  output  1  pm indicator.
REQ-015 Port: sec_pulse  output  1  one-cycle pulse, asserted for one cycle whenever the seconds value advances.
REQ-016 Port: day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition.
REQ-017 Port: load_err  output  1  one-cycle pulse when a load or alarm_set is rejected.
REQ-018 Port: alarm_hit  output  1  one-cycle alarm pulse.

Function
REQ-019 Internal time SHALL be held as binary hour 0..23, minute 0..59 and second 0..59; the display SHALL be derived from these values each cycle with no added latency.
REQ-020 Prescaler: when ena=1, count 0..TICK_DIV-1 and then wrap; a tick SHALL occur in a cycle with ena=1 and count=TICK_DIV-1 (every enabled cycle when TICK_DIV=1).
REQ-021 On a tick, seconds SHALL increment; 59 SHALL wrap to 0 and carry to minutes; minute 59 SHALL wrap to 0 and carry to hours; hour 23 SHALL wrap to 0.
REQ-022 sec_pulse and day_wrap SHALL assert in the cycle after the advancing edge, aligned with the new displayed value.
REQ-023 When mode24=1: hh SHALL equal the hour in BCD (00..23) and pm SHALL be 0.
REQ-024 When mode24=0: hour 0 SHALL display as 12 with pm=0; hours 1..11 SHALL display as 01..11 with pm=0; hour 12 SHALL display as 12 with pm=1; hours 13..23 SHALL display as 01..11 with pm=1.
REQ-025 A mode24 change SHALL alter only the display format; internal time SHALL be unaffected.
REQ-026 A load SHALL be valid only if all of the following hold: every nibble is <=9; ld_mm and ld_ss are <=0x59; ld_hh is <=0x23 when mode24=1, or 0x01..0x12 when mode24=0.
REQ-027 A valid load SHALL write the time at that clock edge and clear the prescaler; an invalid load SHALL leave the state unchanged and pulse load_err.
REQ-028 load SHALL take priority over a tick in the same cycle; the tick SHALL be discarded and no sec_pulse SHALL be produced.
REQ-029 If load and alarm_set assert in the same cycle, both SHALL be processed, and load_err SHALL pulse once if either is invalid.

Reset
REQ-030 While reset=1, time SHALL go to 00:00:00 and the prescaler to 0; hh=0x12 when mode24=0 or 0x00 when mode24=1; mm=ss=0x00; pm=0; all pulse outputs SHALL be 0.
REQ-031 Reset SHALL take priority over load, alarm_set and tick; the stored alarm SHALL reset to 00:00.

Configuration
REQ-032 Macro RTC_TIMEKEEPER_ALARM_EN SHALL control the alarm feature.
REQ-033 With RTC_TIMEKEEPER_ALARM_EN defined:
- alarm_set SHALL store the alarm with the same validation as REQ-026 (seconds check omitted).
- alarm_hit SHALL pulse for one cycle when a tick advances the time to alarm hh:mm:00 while alarm_arm=1.
- A load that lands exactly on hh:mm:00 SHALL NOT trigger alarm_hit.
REQ-034 Without RTC_TIMEKEEPER_ALARM_EN:
- Alarm inputs SHALL be ignored, alarm_hit SHALL be constant 0, and alarm_set SHALL never cause load_err.
- No alarm storage SHALL be synthesised.

Verification
REQ-035 TICK_DIV=4, ena=1 held from reset -> first sec_pulse 4 cycles after reset release; ss=0x01, hh=0x12, pm=0 (mode24=0).
REQ-036 Load 11:59:59 pm=0, mode24=0, TICK_DIV=1 -> next cycle 12:00:00 pm=1; after a load of 11:59:59 pm=1 -> 12:00:00 pm=0 with day_wrap=1.
REQ-037 Load hh=0x13 with mode24=0 -> load_err pulses once and time is unchanged; the same load with mode24=1 -> accepted, hh=0x13, pm=0.
REQ-038 Load asserted in the same cycle as a tick -> the loaded value appears and sec_pulse stays 0; ena=0 for 10 cycles -> no change.
REQ-039 ALARM_EN, alarm 07:30 pm=0, armed, time 07:29:59 -> alarm_hit for exactly one cycle at 07:30:00; alarm_arm=0 -> no hit.
REQ-040 Reset mid-count at 05:17:42 -> next cycle 12:00:00 AM, prescaler restarts from 0.
